// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, driver FSM state type and opcode-range helper.
package alu_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD  = 4'd0;
  localparam op_t OP_ADDC = 4'd1;
  localparam op_t OP_SUB  = 4'd2;
  localparam op_t OP_AND  = 4'd3;
  localparam op_t OP_OR   = 4'd4;
  localparam op_t OP_XOR  = 4'd5;
  localparam op_t OP_NOR  = 4'd6;
  localparam op_t OP_SLT  = 4'd7;
  localparam op_t OP_SHL  = 4'd8;
  localparam op_t OP_SHR  = 4'd9;
  localparam op_t OP_LAST = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  function automatic logic is_err(input op_t op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_driver.sv
// alu_driver: issues one command at a time to an external ALU and returns a tagged response.
// Optional accumulator operand source enabled by defining ALU_DRV_ACC_EN.
module alu_driver
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_acc,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [3:0]       ALU_Sel,
  input  logic [31:0]      ALU_Out,
  input  logic             CarryOut,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] ops_cnt
);

  state_t      state;
  logic [31:0] a_src;
  logic        op_err;

  assign cmd_ready = state == S_IDLE && !rst;
  assign rsp_valid = state == S_RESP && !rst;
  assign op_err    = is_err(ALU_Sel);

`ifdef ALU_DRV_ACC_EN
  logic [31:0] acc;
  assign a_src = cmd_acc ? acc : cmd_a;
  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (state == S_RESP && rsp_ready && !rsp_err)
      acc <= rsp_data;
  end
`else
  logic unused_acc;
  assign unused_acc = cmd_acc;
  assign a_src      = cmd_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      A         <= '0;
      B         <= '0;
      ALU_Sel   <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
      ops_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          A       <= a_src;
          B       <= cmd_b;
          ALU_Sel <= cmd_op;
          rsp_tag <= cmd_tag;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          rsp_data  <= op_err ? '0 : ALU_Out;
          rsp_carry <= op_err ? 1'b0 : CarryOut;
          rsp_err   <= op_err;
          state     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          ops_cnt <= ops_cnt + 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of command/response tag.
REQ-002 SHALL have parameter CNT_W, default 16, width of completed-operation counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  driver accepts command.
REQ-007 SHALL have port cmd_op  input  4  ALU opcode.
REQ-008 SHALL have port cmd_a / cmd_b  input  32 each  operands.
REQ-009 SHALL have port cmd_acc  input  1  replace cmd_a with accumulator.
REQ-010 SHALL have port cmd_tag  input  TAG_W  command identifier.
REQ-011 SHALL have port A / B  output  32 each  registered ALU operands.
REQ-012 SHALL have port ALU_Sel  output  4  registered ALU opcode.
REQ-013 SHALL have port ALU_Out  input  32  combinational ALU result.
REQ-014 SHALL have port CarryOut  input  1  combinational ALU carry.
REQ-015 SHALL have port rsp_valid  output  1  response present.
REQ-016 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-017 SHALL have ports rsp_data (32), rsp_carry (1), rsp_err (1), rsp_tag (TAG_W)  outputs  response fields.
REQ-018 SHALL have port ops_cnt  output  CNT_W  count of completed responses.

Function
REQ-019 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other states.
REQ-020 IDLE: cmd_ready=1; on cmd_valid&cmd_ready SHALL register A, B, ALU_Sel, tag and go to EXEC.
REQ-021 EXEC: cmd_ready=0; SHALL capture ALU_Out, CarryOut into rsp_data, rsp_carry at cycle end and go to RESP.
REQ-022 RESP: rsp_valid=1; SHALL hold all rsp_* fields stable until rsp_valid&rsp_ready, then go to IDLE.
REQ-023 Latency: handshake at cycle N SHALL give rsp_valid at cycle N+2; max throughput one command per 3 cycles.
REQ-024 cmd_ready SHALL be 1 only in IDLE; no command acceptance in the cycle a response retires.
REQ-025 Opcodes 4'hA-4'hF SHALL set rsp_err=1 and force rsp_data=0, rsp_carry=0; latency unchanged.
REQ-026 rsp_carry SHALL be registered CarryOut for every opcode (0 from ALU except ADDC).
REQ-027 ops_cnt SHALL increment on each response handshake, including errors, wrapping all-ones -> 0.
REQ-028 A, B, ALU_Sel SHALL hold last issued values outside EXEC.

Reset
REQ-029 rst SHALL force IDLE and zero A, B, ALU_Sel, rsp_data, rsp_carry, rsp_err, rsp_tag, ops_cnt, accumulator; rsp_valid=0, cmd_ready=0 during reset.
REQ-030 rst in EXEC or RESP SHALL drop the in-flight operation with no response and no counter increment.
REQ-031 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 Macro ALU_DRV_ACC_EN defined: 32-bit accumulator loaded with rsp_data at each non-error response handshake; cmd_acc=1 SHALL issue A=accumulator instead of cmd_a.
REQ-033 Macro ALU_DRV_ACC_EN undefined: no accumulator register; cmd_acc SHALL be ignored, A=cmd_a always.

Structure
REQ-034 Package alu_pkg SHALL hold opcode constants OP_ADD=0, OP_ADDC=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_NOR=6, OP_SLT=7, OP_SHL=8, OP_SHR=9, OP_LAST=9, and the FSM state type.
REQ-035 Module SHALL be flat, no sub-module; ALU is external and connected via A/B/ALU_Sel/ALU_Out/CarryOut.

Verification
REQ-036 ADD 5+7, tag 3, rsp_ready=1 -> rsp_valid at N+2, rsp_data=12, rsp_carry=0, rsp_tag=3, ops_cnt=1.
REQ-037 ADDC 32'hFFFFFFFF+1 -> rsp_data=0, rsp_carry=1.
REQ-038 rsp_ready low 5 cycles in RESP -> all rsp_* stable, cmd_ready=0, ops_cnt unchanged until handshake.
REQ-039 cmd_op=4'hC, cmd_a=9 -> rsp_err=1, rsp_data=0; ops_cnt increments.
REQ-040 ACC_EN: ADD 10+5 then cmd_acc=1 SUB b=3 -> A=15 issued, rsp_data=12; without macro second rsp_data=cmd_a-3.
REQ-041 rst pulsed in EXEC -> no rsp_valid, ops_cnt=0, cmd_ready=1 next cycle; CNT_W=4 with 16 commands -> ops_cnt wraps to 0.
